// File: rtl/nd_2to1_pkg.sv
// Shared message-field widths, FIFO depth, on/off constants and output FSM
// encoding for the nd_2to1 merge node.
package nd_2to1_pkg;

  localparam int NS_MESSAGE_FIFO_SIZE = 4;
  localparam int NS_ADDRESS_SIZE      = 4;
  localparam int NS_DATA_SIZE         = 8;
  localparam int NS_REDUN_SIZE        = 4;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  // Width of one packed {src, dst, dat, red} message.
  function automatic int msg_width(input int asz, input int dsz, input int rsz);
    return 2 * asz + dsz + rsz;
  endfunction

endpackage

// File: rtl/nd_2to1_fifo.sv
// Synchronous message FIFO holding packed {src, dst, dat, red} words, with
// push/pop/full/empty/count and an asynchronous active-low reset.
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even if it is popped in the same cycle.
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // NOTE: storage is deliberately not reset; pointers and count alone decide
  // which entries are valid, so clearing the array would only cost logic.
  // NOTE: every clocked assignment uses <= so all registers update together.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

endmodule

// File: rtl/nd_2to1.sv
// Two-input merge node: 4-phase input channels into per-input FIFOs, drained
// round-robin onto one 4-phase output channel with payload unchanged.
module nd_2to1
  import nd_2to1_pkg::*;
#(
  parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  input  logic           rcv1_req,
  output logic           rcv1_ack,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req,
  input  logic           snd0_ack
);

  localparam int MW = msg_width(ASZ, DSZ, RSZ);
  localparam int AW = $clog2(FSZ);

  logic          r_ready;
  logic [1:0]    r_rcv_ack;
  logic [1:0]    r_state;
  logic          r_snd_req;
  logic          r_last;
  logic [MW-1:0] r_snd_msg;

  logic [1:0]    w_rcv_req;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_full;
  logic [1:0]    w_empty;
  logic [MW-1:0] w_rcv_msg [2];
  logic [MW-1:0] w_head [2];
  logic [AW:0]   w_count [2];
  logic          w_pick;
  logic          w_start;

  assign w_rcv_req    = {rcv1_req, rcv0_req};
  assign w_rcv_msg[0] = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
  assign w_rcv_msg[1] = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) r_ready <= NS_OFF;
    else        r_ready <= NS_ON;
  end

  // Accept only while ack is low, so each req pulse yields exactly one push.
  assign w_push = {2{r_ready}} & w_rcv_req & ~r_rcv_ack & ~w_full;

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_rcv_ack <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_push[k])          r_rcv_ack[k] <= NS_ON;
        else if (!w_rcv_req[k]) r_rcv_ack[k] <= NS_OFF;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    msg_fifo #(
      .DEPTH (FSZ),
      .WIDTH (MW)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (reset),
      .i_push  (w_push[k]),
      .i_din   (w_rcv_msg[k]),
      .i_pop   (w_pop[k]),
      .o_dout  (w_head[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_count (w_count[k])
    );

    a_count_bound : assert property (@(posedge i_clk) disable iff (!reset)
      w_count[k] <= (AW+1)'(FSZ));
  end

  // Round-robin: a lone non-empty FIFO wins; on a tie, the one not served last.
  always_comb begin
    // NOTE: default before any branch so no path leaves w_pick unassigned.
    w_pick = 1'b0;
    if (!w_empty[0] && !w_empty[1]) w_pick = ~r_last;
    else if (w_empty[0])            w_pick = 1'b1;
  end

  assign w_start = r_ready && (r_state == ST_IDLE) && !(&w_empty);
  assign w_pop   = {w_start & w_pick, w_start & ~w_pick};

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_snd_req <= NS_OFF;
      r_last    <= 1'b1;
      r_snd_msg <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_snd_msg <= w_head[w_pick];
            r_snd_req <= NS_ON;
            r_last    <= w_pick;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (snd0_ack) begin
            r_snd_req <= NS_OFF;
            r_state   <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!snd0_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready    = r_ready;
  assign rcv0_ack = r_rcv_ack[0];
  assign rcv1_ack = r_rcv_ack[1];
  assign snd0_req = r_snd_req;
  assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = r_snd_msg;

endmodule

// File: tb/tb_nd_2to1.sv
// Self-checking bench for nd_2to1: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_nd_2to1;
  import nd_2to1_pkg::*;

  localparam int FSZ = 4;
  localparam int ASZ = 4;
  localparam int DSZ = 8;
  localparam int RSZ = 4;
  localparam int MW  = 2 * ASZ + DSZ + RSZ;
  localparam int TMO = 400;

  typedef logic [MW-1:0] msg_t;

  logic           i_clk;
  logic           reset;
  logic           ready;
  logic [ASZ-1:0] rcv0_src, rcv0_dst, rcv1_src, rcv1_dst, snd0_src, snd0_dst;
  logic [DSZ-1:0] rcv0_dat, rcv1_dat, snd0_dat;
  logic [RSZ-1:0] rcv0_red, rcv1_red, snd0_red;
  logic           rcv0_req, rcv0_ack, rcv1_req, rcv1_ack, snd0_req, snd0_ack;

  msg_t       drv_msg [2];
  logic [1:0] drv_req;
  msg_t       snd_msg;

  assign {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = drv_msg[0];
  assign {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red} = drv_msg[1];
  assign rcv0_req = drv_req[0];
  assign rcv1_req = drv_req[1];
  assign snd_msg  = {snd0_src, snd0_dst, snd0_dat, snd0_red};

  nd_2to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .ready    (ready),
    .rcv0_src (rcv0_src),
    .rcv0_dst (rcv0_dst),
    .rcv0_dat (rcv0_dat),
    .rcv0_red (rcv0_red),
    .rcv0_req (rcv0_req),
    .rcv0_ack (rcv0_ack),
    .rcv1_src (rcv1_src),
    .rcv1_dst (rcv1_dst),
    .rcv1_dat (rcv1_dat),
    .rcv1_red (rcv1_red),
    .rcv1_req (rcv1_req),
    .rcv1_ack (rcv1_ack),
    .snd0_src (snd0_src),
    .snd0_dst (snd0_dst),
    .snd0_dat (snd0_dat),
    .snd0_red (snd0_red),
    .snd0_req (snd0_req),
    .snd0_ack (snd0_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic msg_t mk(input int src, input int dst, input int dat, input int red);
    return {ASZ'(src), ASZ'(dst), DSZ'(dat), RSZ'(red)};
  endfunction

  function automatic logic get_ack(input int k);
    return (k == 0) ? rcv0_ack : rcv1_ack;
  endfunction

  // Reference model: messages held in each input FIFO, last-served input,
  // and the log of everything delivered on the output channel.
  msg_t q0[$];
  msg_t q1[$];
  bit   m_last;
  msg_t out_log[$];

  // Output responder: answers req with ack, optionally after a random delay.
  bit resp_hold = 1'b0;
  bit resp_rand = 1'b0;
  int resp_cnt  = 0;

  initial begin
    snd0_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!reset) begin
        snd0_ack = 1'b0;
        resp_cnt = 0;
      end else if (snd0_req && !snd0_ack && !resp_hold) begin
        if (resp_cnt > 0) resp_cnt--;
        else begin
          snd0_ack = 1'b1;
          resp_cnt = resp_rand ? int'($urandom_range(0, 3)) : 0;
        end
      end else if (!snd0_req && snd0_ack) begin
        snd0_ack = 1'b0;
      end
    end
  end

  // Compare process: inputs sampled at the edge, outputs 1 time unit later.
  initial begin
    msg_t       e_msg [2];
    logic [1:0] e_req;
    logic       e_sack, e_rst;
    logic       p_ack [2];
    logic       p_ready, p_sreq;
    msg_t       p_smsg;
    bit         exp_push [2];
    logic       exp_ack;
    int         ch, occ;
    m_last = 1'b1;
    forever begin
      @(posedge i_clk);
      e_req  = drv_req;
      e_msg  = drv_msg;
      e_sack = snd0_ack;
      e_rst  = reset;
      #1;
      if (!e_rst || !reset) begin
        q0.delete();
        q1.delete();
        m_last = 1'b1;
      end else begin
        check("ready_high", ready, 1);
        for (int k = 0; k < 2; k++) begin
          occ = (k == 0) ? q0.size() : q1.size();
          exp_push[k] = p_ready && e_req[k] && !p_ack[k] && (occ < FSZ);
          exp_ack = exp_push[k] ? 1'b1 : (e_req[k] ? p_ack[k] : 1'b0);
          check($sformatf("rcv%0d_ack", k), get_ack(k), exp_ack);
        end
        if (p_sreq) check("snd_req_vs_ack", snd0_req, !e_sack);
        if (p_sreq && snd0_req) check("snd_fields_stable", snd_msg, p_smsg);
        if (snd0_req && !p_sreq) begin
          if (q0.size() == 0 && q1.size() == 0) begin
            check("pop_from_empty", snd0_req, 0);
          end else begin
            if (q0.size() != 0 && q1.size() != 0) ch = m_last ? 0 : 1;
            else ch = (q0.size() != 0) ? 0 : 1;
            if (ch == 0) begin
              check("snd_msg_from_rcv0", snd_msg, q0[0]);
              void'(q0.pop_front());
            end else begin
              check("snd_msg_from_rcv1", snd_msg, q1[0]);
              void'(q1.pop_front());
            end
            m_last = (ch != 0);
            out_log.push_back(snd_msg);
          end
        end
        if (exp_push[0]) q0.push_back(e_msg[0]);
        if (exp_push[1]) q1.push_back(e_msg[1]);
      end
      p_ack[0] = rcv0_ack;
      p_ack[1] = rcv1_ack;
      p_ready  = ready;
      p_sreq   = snd0_req;
      p_smsg   = snd_msg;
    end
  end

  task automatic send(input int k, input msg_t m);
    int t;
    drv_msg[k] = m;
    drv_req[k] = 1'b1;
    t = 0;
    while (!get_ack(k) && t < TMO) begin @(negedge i_clk); t++; end
    if (t >= TMO) check($sformatf("rcv%0d_ack_rise_timeout", k), get_ack(k), 1);
    drv_req[k] = 1'b0;
    t = 0;
    while (get_ack(k) && t < TMO) begin @(negedge i_clk); t++; end
    if (t >= TMO) check($sformatf("rcv%0d_ack_fall_timeout", k), get_ack(k), 0);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    do begin
      @(negedge i_clk);
      t++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !snd0_req && !snd0_ack) && t < TMO);
    if (t >= TMO) check({name, "_drain_timeout"}, t, 0);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int exp_cont [6] = '{1, 11, 2, 12, 3, 13};
    reset      = 1'b0;
    drv_req    = '0;
    drv_msg[0] = '0;
    drv_msg[1] = '0;
    repeat (3) @(negedge i_clk);

    // Reset state
    check("rst_ready", ready, 0);
    check("rst_rcv0_ack", rcv0_ack, 0);
    check("rst_rcv1_ack", rcv1_ack, 0);
    check("rst_snd0_req", snd0_req, 0);
    check("rst_snd_fields", snd_msg, 0);
    reset = 1'b1;
    @(posedge i_clk); #1;
    check("init_ready", ready, 1);

    // Single message on input 0
    @(negedge i_clk);
    out_log.delete();
    fork send(0, mk(3, 5, 'hA5, 9)); join_none
    @(posedge i_clk); #1;
    check("single_ack_one_edge", rcv0_ack, 1);
    wait fork;
    wait_drain("single");
    check("single_count", out_log.size(), 1);
    if (out_log.size() == 1) check("single_msg", out_log[0], mk(3, 5, 'hA5, 9));

    // Reset in the middle of SEND
    resp_hold = 1'b1;
    send(0, mk(1, 2, 'h77, 3));
    t = 0;
    while (!snd0_req && t < TMO) begin @(negedge i_clk); t++; end
    check("midsend_req_up", snd0_req, 1);
    @(negedge i_clk);
    #2 reset = 1'b0;
    #1;
    check("midsend_snd0_req", snd0_req, 0);
    check("midsend_rcv0_ack", rcv0_ack, 0);
    check("midsend_rcv1_ack", rcv1_ack, 0);
    check("midsend_ready", ready, 0);
    check("midsend_fields", snd_msg, 0);
    @(negedge i_clk);
    resp_hold = 1'b0;
    reset = 1'b1;
    @(posedge i_clk); #1;
    check("midsend_ready_back", ready, 1);
    repeat (3) @(negedge i_clk);
    check("midsend_fifos_empty", snd0_req, 0);

    // Contention: round-robin interleaving
    out_log.delete();
    fork
      begin for (int i = 1; i <= 3; i++) send(0, mk(1, 6, i, 1)); end
      begin for (int i = 11; i <= 13; i++) send(1, mk(2, 6, i, 2)); end
    join
    wait_drain("contention");
    check("contention_count", out_log.size(), 6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      check($sformatf("contention_dat_%0d", i), out_log[i][RSZ +: DSZ], exp_cont[i]);

    // Backpressure on input 1
    resp_hold = 1'b1;
    out_log.delete();
    fork
      begin for (int i = 0; i < FSZ + 2; i++) send(1, mk(4, 7, 20 + i, i)); end
    join_none
    repeat (30) @(negedge i_clk);
    check("bp_req_held", rcv1_req, 1);
    check("bp_ack_low", rcv1_ack, 0);
    check("bp_model_full", q1.size(), FSZ);
    check("bp_out_reg_dat", snd0_dat, 20);
    resp_hold = 1'b0;
    wait fork;
    wait_drain("backpressure");
    check("bp_count", out_log.size(), FSZ + 2);
    for (int i = 0; i < FSZ + 2 && i < out_log.size(); i++)
      check($sformatf("bp_dat_%0d", i), out_log[i][RSZ +: DSZ], 20 + i);

    // Simultaneous push and pop on FIFO 0
    resp_hold = 1'b1;
    out_log.delete();
    send(0, mk(5, 1, 'h31, 0));
    send(0, mk(5, 1, 'h32, 0));
    repeat (3) @(negedge i_clk);
    check("sim_model_one_queued", q0.size(), 1);
    resp_hold = 1'b0;
    t = 0;
    do begin @(posedge i_clk); t++; end while (snd0_ack !== 1'b1 && t < TMO);
    do begin @(posedge i_clk); t++; end while (snd0_ack !== 1'b0 && t < TMO);
    @(negedge i_clk);
    fork send(0, mk(5, 1, 'h33, 0)); join_none
    @(posedge i_clk); #1;
    check("sim_push_ack", rcv0_ack, 1);
    check("sim_pop_req", snd0_req, 1);
    check("sim_pop_dat", snd0_dat, 'h32);
    wait fork;
    wait_drain("simultaneous");
    check("sim_count", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++)
      check($sformatf("sim_dat_%0d", i), out_log[i][RSZ +: DSZ], 'h31 + i);

    // Wrap-around: 3*FSZ messages with random delays on both sides
    resp_rand = 1'b1;
    out_log.delete();
    for (int i = 0; i < 3 * FSZ; i++) begin
      send(0, mk(i % 16, (i + 3) % 16, 'h40 + i, i % 16));
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end
    wait_drain("wrap");
    check("wrap_count", out_log.size(), 3 * FSZ);
    for (int i = 0; i < 3 * FSZ && i < out_log.size(); i++)
      check($sformatf("wrap_dat_%0d", i), out_log[i][RSZ +: DSZ], 'h40 + i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
